// File: rtl/alu_pkg.sv
// Shared ALU slice types: command encodings, the decoded control word and slice width.
package alu_pkg;

  localparam int unsigned ALU_SLICE_W = 4;

  typedef enum logic [1:0] {
    OP_SUM = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } AluOp;

  // Bit 4 of the control word is the slice carry_in.
  typedef struct packed {
    logic carry_in;
    logic invert_b;
    logic carry_disable;
    AluOp op;
  } AluCtrlInternal;

  typedef logic [4:0] AluCtrl;

  typedef enum logic [4:0] {
    CMD_ADD  = 5'b00000,
    CMD_SUB  = 5'b11000,
    CMD_COMP = 5'b01000,
    CMD_AND  = 5'b00101,
    CMD_OR   = 5'b00110,
    CMD_XOR  = 5'b00111
  } AluCmd;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DONE
  } seq_state_e;

endpackage

// File: rtl/alu.sv
// 4-bit combinational ALU slice: add / add-inverted with carry, plus bitwise logic ops.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_SLICE_W-1:0] d1,
  input  logic [ALU_SLICE_W-1:0] d2,
  input  AluCtrl                 ctrl,
  output logic [ALU_SLICE_W-1:0] res,
  output logic                   carry_out
);

  AluCtrlInternal             c;
  logic [ALU_SLICE_W-1:0]     b_eff;
  logic [ALU_SLICE_W:0]       sum;

  always_comb begin
    c         = AluCtrlInternal'(ctrl);
    b_eff     = c.invert_b ? ~d2 : d2;
    // The adder always runs so carry_out stays meaningful (raw) for logic ops.
    sum       = {1'b0, d1} + {1'b0, b_eff}
              + {{ALU_SLICE_W{1'b0}}, c.carry_in & ~c.carry_disable};
    carry_out = sum[ALU_SLICE_W];
    case (c.op)
      OP_SUM:  res = sum[ALU_SLICE_W-1:0];
      OP_AND:  res = d1 & d2;
      OP_OR:   res = d1 | d2;
      OP_XOR:  res = d1 ^ d2;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// Drives one 4-bit alu slice LS nibble first, chaining carry, to build a NIBBLES*4-bit result.
module alu_nibble_seq
  import alu_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [4:0]                       in_cmd,
  input  logic [ALU_SLICE_W*NIBBLES-1:0]   in_a,
  input  logic [ALU_SLICE_W*NIBBLES-1:0]   in_b,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ALU_SLICE_W*NIBBLES-1:0]   out_res,
  output logic                             out_carry,
  output logic [ALU_SLICE_W-1:0]           alu_d1,
  output logic [ALU_SLICE_W-1:0]           alu_d2,
  output AluCtrl                           alu_ctrl,
  input  logic [ALU_SLICE_W-1:0]           alu_res,
  input  logic                             alu_carry
);

  localparam int unsigned W  = ALU_SLICE_W * NIBBLES;
  localparam int unsigned NW = $clog2(NIBBLES);

  seq_state_e     state_q, state_d;
  logic [NW-1:0]  nib_q, nib_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;
  logic [4:0]     cmd_q, cmd_d;
  logic           carry_q, carry_d;
  logic           last_nib;

  assign last_nib = (nib_q == NW'(NIBBLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
      nib_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cmd_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cmd_q   <= cmd_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cmd_d   = cmd_q;
    carry_d = carry_q;
    case (state_q)
      SEQ_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cmd_d   = in_cmd;
          nib_d   = '0;
          state_d = SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        res_d[ALU_SLICE_W*nib_q +: ALU_SLICE_W] = alu_res;
        carry_d = alu_carry;
        nib_d   = nib_q + 1'b1;
        if (last_nib) begin
          nib_d   = '0;
          state_d = SEQ_DONE;
        end
      end
      SEQ_DONE: begin
        if (out_ready) state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == SEQ_IDLE);
    out_valid = (state_q == SEQ_DONE);
    out_res   = res_q;
    out_carry = carry_q;
    alu_d1    = '0;
    alu_d2    = '0;
    alu_ctrl  = '0;
    if (state_q == SEQ_RUN) begin
      alu_d1   = a_q[ALU_SLICE_W*nib_q +: ALU_SLICE_W];
      alu_d2   = b_q[ALU_SLICE_W*nib_q +: ALU_SLICE_W];
      // Nibble 0 seeds carry_in only for SUB; later nibbles take the chained carry.
      alu_ctrl = {(nib_q == '0) ? (cmd_q[4:3] == 2'b11) : carry_q, cmd_q[3:0]};
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq wired to one alu slice.
module tb_alu_nibble_seq;
  import alu_pkg::*;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   in_cmd = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_res;
  logic         out_carry;
  logic [3:0]   alu_d1, alu_d2, alu_res;
  AluCtrl       alu_ctrl;
  logic         alu_carry;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_carry(out_carry),
    .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_ctrl(alu_ctrl),
    .alu_res(alu_res), .alu_carry(alu_carry)
  );

  alu u_alu (
    .d1(alu_d1), .d2(alu_d2), .ctrl(alu_ctrl),
    .res(alu_res), .carry_out(alu_carry)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"},  32'(in_ready),  32'd1);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".out_res"},   32'(out_res),   32'd0);
    check({tag, ".out_carry"}, 32'(out_carry), 32'd0);
    check({tag, ".alu_d1"},    32'(alu_d1),    32'd0);
    check({tag, ".alu_d2"},    32'(alu_d2),    32'd0);
    check({tag, ".alu_ctrl"},  32'(alu_ctrl),  32'd0);
  endtask

  task automatic run_op(input string tag, input logic [4:0] cmd,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input logic exp_carry,
                        input bit chk_trace, input logic [3:0] exp_trace,
                        input int unsigned hold);
    logic [3:0]  trace;
    int unsigned cyc;
    trace = '0;
    @(negedge clk);
    check({tag, ".accept_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_cmd = cmd; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      if (cyc < NIB) begin
        trace[cyc] = alu_ctrl[4];
        check({tag, ".d1"}, 32'(alu_d1), 32'(a[4*cyc +: 4]));
        check({tag, ".d2"}, 32'(alu_d2), 32'(b[4*cyc +: 4]));
        check({tag, ".run_ready"}, 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'(NIB));
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".res"}, 32'(out_res), 32'(exp_res));
    check({tag, ".carry"}, 32'(out_carry), 32'(exp_carry));
    if (chk_trace) check({tag, ".cin_trace"}, 32'(trace), 32'(exp_trace));
    if (hold > 0) begin
      in_valid = 1'b1;
      for (int unsigned i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".hold_res"},   32'(out_res),   32'(exp_res));
        check({tag, ".hold_carry"}, 32'(out_carry), 32'(exp_carry));
        check({tag, ".hold_ready"}, 32'(in_ready),  32'd0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".drain_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".drain_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_0fff", CMD_ADD,  16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b1, 4'b1110, 0);
    run_op("add_ffff", CMD_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 4'b1110, 0);
    run_op("sub_1000", CMD_SUB,  16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b1, 4'b0001, 0);
    run_op("sub_0001", CMD_SUB,  16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0, 4'b0000, 0);
    run_op("comp_gt",  CMD_COMP, 16'h1234, 16'h1233, 16'h0000, 1'b1, 1'b0, 4'b0000, 0);
    run_op("comp_lt",  CMD_COMP, 16'h1233, 16'h1234, 16'hFFFE, 1'b0, 1'b0, 4'b0000, 0);
    run_op("comp_eq",  CMD_COMP, 16'h5555, 16'h5555, 16'hFFFF, 1'b0, 1'b0, 4'b0000, 0);
    run_op("and",      CMD_AND,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b1, 1'b0, 4'b0000, 0);
    run_op("xor",      CMD_XOR,  16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b1, 1'b0, 4'b0000, 3);
    run_op("or",       CMD_OR,   16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b1, 1'b0, 4'b0000, 0);

    // Abort an ADD after nibble 1 has been written into the result register.
    @(negedge clk);
    in_valid = 1'b1; in_cmd = CMD_ADD; in_a = 16'h1111; in_b = 16'h2222;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    run_op("add_after_abort", CMD_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 4'b0000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
